// File: rtl/riscp_pkg.sv
// Shared definitions for the pipeline: datapath sizes, ALU op codes and
// the forward-select encoding used by the operand bypass muxes.
package riscp_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [2:0] ALU_NOR = 3'b000;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_EXM = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// Operand bypass for one source register: picks the youngest in-flight
// producer (EX/MEM first, then WB) and falls back to the registered value.
// Register zero is never overridden because it is hard-wired to zero.
module fwd_select #(
    parameter int XLEN    = riscp_pkg::XLEN,
    parameter int RADDR_W = riscp_pkg::RADDR_W
) (
    input  logic [RADDR_W-1:0] src_addr,
    input  logic [XLEN-1:0]    reg_data,
    input  logic               exm_reg_write,
    input  logic [RADDR_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]    exm_result,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    fwd_data,
    output riscp_pkg::fwd_sel_t sel
);
    import riscp_pkg::*;

    // Choose the producer: EX/MEM is younger than WB so it wins a tie.
    always_comb begin
        sel = FWD_REG;
        if (exm_reg_write && (exm_rd_addr == src_addr) && (src_addr != '0)) begin
            sel = FWD_EXM;
        end else if (wb_reg_write && (wb_rd_addr == src_addr) && (src_addr != '0)) begin
            sel = FWD_WB;
        end
    end

    // Steer the data according to the chosen producer.
    always_comb begin
        fwd_data = reg_data;
        case (sel)
            FWD_EXM: fwd_data = exm_result;
            FWD_WB:  fwd_data = wb_data;
            default: fwd_data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding in front of the ALU.
// Detects load-use hazards against the instruction in ID, inserts a bubble
// for them, and obeys the global stall and the branch flush.
module id_ex_stage #(
    parameter int XLEN    = riscp_pkg::XLEN,
    parameter int RADDR_W = riscp_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs_addr,
    input  logic [RADDR_W-1:0] id_rt_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0]    id_rs_data,
    input  logic [XLEN-1:0]    id_rt_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic               id_use_imm,
    input  logic [2:0]         id_alu_op,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               exm_reg_write,
    input  logic [RADDR_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0]    exm_result,
    input  logic               wb_reg_write,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               load_use_stall,
    output logic               ex_valid,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [2:0]         alu_op,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write
);
    import riscp_pkg::*;

    logic [RADDR_W-1:0] rs_addr_q;
    logic [RADDR_W-1:0] rt_addr_q;
    logic [XLEN-1:0]    rs_data_q;
    logic [XLEN-1:0]    rt_data_q;
    logic [XLEN-1:0]    imm_q;
    logic               use_imm_q;
    logic               reg_write_q;
    logic               mem_read_q;
    logic               mem_write_q;

    logic [XLEN-1:0]    cap_rs_data;
    logic [XLEN-1:0]    cap_rt_data;
    logic               rt_used;
    logic               bubble;

    logic [XLEN-1:0]    rs_fwd;
    logic [XLEN-1:0]    rt_fwd;
    fwd_sel_t           rs_sel;
    fwd_sel_t           rt_sel;
    logic               unused_sel;

    // A WB write landing in the same cycle as the register-file read is not
    // yet visible in the read data, so bypass it while capturing.
    always_comb begin
        cap_rs_data = id_rs_data;
        cap_rt_data = id_rt_data;
        if (wb_reg_write && (wb_rd_addr == id_rs_addr) && (id_rs_addr != '0)) begin
            cap_rs_data = wb_data;
        end
        if (wb_reg_write && (wb_rd_addr == id_rt_addr) && (id_rt_addr != '0)) begin
            cap_rt_data = wb_data;
        end
    end

    // A load in EX cannot supply its data until MEM, so the consumer in ID
    // must wait one cycle; a flush squashes the consumer anyway.
    always_comb begin
        rt_used        = !id_use_imm || id_mem_write;
        load_use_stall = 1'b0;
        if (!flush && ex_valid && mem_read_q && id_valid && (ex_rd_addr != '0)) begin
            load_use_stall = (ex_rd_addr == id_rs_addr) ||
                             (rt_used && (ex_rd_addr == id_rt_addr));
        end
        bubble = flush || load_use_stall;
    end

    // Pipeline register: stall holds, flush or hazard loads a bubble,
    // otherwise the ID fields are captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_op      <= ALU_NOR;
            ex_rd_addr  <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!stall) begin
            if (bubble) begin
                ex_valid    <= 1'b0;
                rs_addr_q   <= '0;
                rt_addr_q   <= '0;
                rs_data_q   <= '0;
                rt_data_q   <= '0;
                imm_q       <= '0;
                use_imm_q   <= 1'b0;
                alu_op      <= ALU_NOR;
                ex_rd_addr  <= '0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                rs_addr_q   <= id_rs_addr;
                rt_addr_q   <= id_rt_addr;
                rs_data_q   <= cap_rs_data;
                rt_data_q   <= cap_rt_data;
                imm_q       <= id_imm;
                use_imm_q   <= id_use_imm;
                alu_op      <= id_alu_op;
                ex_rd_addr  <= id_rd_addr;
                reg_write_q <= id_reg_write;
                mem_read_q  <= id_mem_read;
                mem_write_q <= id_mem_write;
            end
        end
    end

    fwd_select #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs (
        .src_addr      (rs_addr_q),
        .reg_data      (rs_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data      (rs_fwd),
        .sel           (rs_sel)
    );

    fwd_select #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rt (
        .src_addr      (rt_addr_q),
        .reg_data      (rt_data_q),
        .exm_reg_write (exm_reg_write),
        .exm_rd_addr   (exm_rd_addr),
        .exm_result    (exm_result),
        .wb_reg_write  (wb_reg_write),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .fwd_data      (rt_fwd),
        .sel           (rt_sel)
    );

    // The select codes are kept on the sub-module for debug visibility only.
    assign unused_sel = ^{rs_sel, rt_sel};

    // ALU operand steering and control gating: a bubble never writes.
    always_comb begin
        alu_a         = rs_fwd;
        alu_b         = use_imm_q ? imm_q : rt_fwd;
        ex_store_data = rt_fwd;
        ex_reg_write  = ex_valid && reg_write_q;
        ex_mem_read   = ex_valid && mem_read_q;
        ex_mem_write  = ex_valid && mem_write_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a behavioural EX-slot model is
// compared on every falling edge, and directed scenarios add literal checks.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs_addr = '0;
    logic [4:0]  id_rt_addr = '0;
    logic [4:0]  id_rd_addr = '0;
    logic [31:0] id_rs_data = '0;
    logic [31:0] id_rt_data = '0;
    logic [31:0] id_imm = '0;
    logic        id_use_imm = 1'b0;
    logic [2:0]  id_alu_op = '0;
    logic        id_reg_write = 1'b0;
    logic        id_mem_read = 1'b0;
    logic        id_mem_write = 1'b0;
    logic        exm_reg_write = 1'b0;
    logic [4:0]  exm_rd_addr = '0;
    logic [31:0] exm_result = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd_addr = '0;
    logic [31:0] wb_data = '0;

    logic        load_use_stall;
    logic        ex_valid;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    int nVectors = 0;
    int nMiscompares = 0;

    id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .id_valid       (id_valid),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rd_addr     (id_rd_addr),
        .id_rs_data     (id_rs_data),
        .id_rt_data     (id_rt_data),
        .id_imm         (id_imm),
        .id_use_imm     (id_use_imm),
        .id_alu_op      (id_alu_op),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .exm_reg_write  (exm_reg_write),
        .exm_rd_addr    (exm_rd_addr),
        .exm_result     (exm_result),
        .wb_reg_write   (wb_reg_write),
        .wb_rd_addr     (wb_rd_addr),
        .wb_data        (wb_data),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_op         (alu_op),
        .ex_store_data  (ex_store_data),
        .ex_rd_addr     (ex_rd_addr),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Contents of the EX slot as an architectural record.
    typedef struct packed {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] imm;
        logic        ui;
        logic [2:0]  op;
        logic        rw;
        logic        mr;
        logic        mw;
    } ex_model_t;

    ex_model_t m;

    // Value a reader of register a sees, given the in-flight writers.
    function automatic logic [31:0] modelFwd(input logic [4:0] a, input logic [31:0] v);
        if (a == 5'd0) return v;
        if (exm_reg_write && exm_rd_addr == a) return exm_result;
        if (wb_reg_write && wb_rd_addr == a) return wb_data;
        return v;
    endfunction

    // Register-file read corrected for a same-cycle write-back.
    function automatic logic [31:0] modelRead(input logic [4:0] a, input logic [31:0] v);
        if (a != 5'd0 && wb_reg_write && wb_rd_addr == a) return wb_data;
        return v;
    endfunction

    // ID must wait when it reads the register an in-EX load will produce.
    function automatic logic modelHazard();
        logic readsRt;
        readsRt = !id_use_imm || id_mem_write;
        if (flush || !m.v || !m.mr || !id_valid || m.rd == 5'd0) return 1'b0;
        if (m.rd == id_rs_addr) return 1'b1;
        if (readsRt && m.rd == id_rt_addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic ex_model_t modelCapture();
        ex_model_t n;
        n.v   = id_valid;
        n.rs  = id_rs_addr;
        n.rt  = id_rt_addr;
        n.rd  = id_rd_addr;
        n.rsv = modelRead(id_rs_addr, id_rs_data);
        n.rtv = modelRead(id_rt_addr, id_rt_data);
        n.imm = id_imm;
        n.ui  = id_use_imm;
        n.op  = id_alu_op;
        n.rw  = id_reg_write;
        n.mr  = id_mem_read;
        n.mw  = id_mem_write;
        return n;
    endfunction

    // Model of the EX slot advancing on each rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else if (!stall) begin
            if (flush || modelHazard()) m <= '0;
            else m <= modelCapture();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every falling edge: all DUT outputs against the model.
    always @(negedge clk) begin
        checkOutput("m_load_use_stall", load_use_stall, modelHazard());
        checkOutput("m_ex_valid", ex_valid, m.v);
        checkOutput("m_alu_a", alu_a, modelFwd(m.rs, m.rsv));
        checkOutput("m_alu_b", alu_b, m.ui ? m.imm : modelFwd(m.rt, m.rtv));
        checkOutput("m_alu_op", alu_op, m.op);
        checkOutput("m_store_data", ex_store_data, modelFwd(m.rt, m.rtv));
        checkOutput("m_rd_addr", ex_rd_addr, m.rd);
        checkOutput("m_reg_write", ex_reg_write, m.v && m.rw);
        checkOutput("m_mem_read", ex_mem_read, m.v && m.mr);
        checkOutput("m_mem_write", ex_mem_write, m.v && m.mw);
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                                 input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic ui, input logic [2:0] op,
                                 input logic rw, input logic mr, input logic mw);
        id_valid     = v;
        id_rs_addr   = rs;
        id_rs_data   = rsd;
        id_rt_addr   = rt;
        id_rt_data   = rtd;
        id_rd_addr   = rd;
        id_imm       = imm;
        id_use_imm   = ui;
        id_alu_op    = op;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
    endtask

    task automatic clearBypass();
        exm_reg_write = 1'b0;
        exm_rd_addr   = '0;
        exm_result    = '0;
        wb_reg_write  = 1'b0;
        wb_rd_addr    = '0;
        wb_data       = '0;
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        step();
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_lus", load_use_stall, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        step();
        rst_n = 1'b1;

        // No hazard: ADD r3(5) + imm 7
        applyStimulus(1, 5'd3, 32'd5, 5'd0, 32'd0, 5'd8, 32'd7, 1, 3'b100, 1, 0, 0);
        step(); #1;
        checkOutput("nohaz_alu_a", alu_a, 32'd5);
        checkOutput("nohaz_alu_b", alu_b, 32'd7);
        checkOutput("nohaz_alu_op", alu_op, 3'b100);
        checkOutput("nohaz_ex_valid", ex_valid, 1);

        // EX/MEM beats WB on rs=4
        applyStimulus(1, 5'd4, 32'h1, 5'd9, 32'h33, 5'd10, 32'd0, 0, 3'b010, 1, 0, 0);
        step();
        exm_reg_write = 1; exm_rd_addr = 5'd4; exm_result = 32'h11;
        wb_reg_write  = 1; wb_rd_addr  = 5'd4; wb_data    = 32'h22;
        #1;
        checkOutput("exm_wins", alu_a, 32'h11);
        checkOutput("exm_store", ex_store_data, 32'h33);
        exm_reg_write = 0;
        #1;
        checkOutput("wb_only", alu_a, 32'h22);
        clearBypass();

        // Register 0 is never forwarded
        applyStimulus(1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd0, 1, 3'b001, 1, 0, 0);
        step();
        exm_reg_write = 1; exm_rd_addr = 5'd0; exm_result = 32'hFF;
        wb_reg_write  = 1; wb_rd_addr  = 5'd0; wb_data    = 32'hEE;
        #1;
        checkOutput("r0_alu_a", alu_a, 32'd0);
        clearBypass();

        // Load-use: LW r6 in EX, SUB reading r6 in ID
        applyStimulus(1, 5'd2, 32'h100, 5'd0, 32'd0, 5'd6, 32'd4, 1, 3'b100, 1, 1, 0);
        step();
        applyStimulus(1, 5'd1, 32'h10, 5'd6, 32'd0, 5'd7, 32'd0, 0, 3'b011, 1, 0, 0);
        #1;
        checkOutput("lu_stall", load_use_stall, 1);
        step();
        checkOutput("lu_bubble_valid", ex_valid, 0);
        checkOutput("lu_bubble_rw", ex_reg_write, 0);
        checkOutput("lu_no_restall", load_use_stall, 0);
        exm_reg_write = 1; exm_rd_addr = 5'd6; exm_result = 32'h55;
        step(); #1;
        checkOutput("lu_sub_valid", ex_valid, 1);
        checkOutput("lu_sub_alu_b", alu_b, 32'h55);
        checkOutput("lu_sub_alu_a", alu_a, 32'h10);
        checkOutput("lu_sub_op", alu_op, 3'b011);

        // Stall + flush: nothing moves until stall drops
        applyStimulus(1, 5'd5, 32'h77, 5'd0, 32'd0, 5'd3, 32'd0, 1, 3'b001, 1, 0, 0);
        stall = 1; flush = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("sf_hold_valid", ex_valid, 1);
            checkOutput("sf_hold_op", alu_op, 3'b011);
            checkOutput("sf_hold_alu_b", alu_b, 32'h55);
        end
        stall = 0;
        step();
        checkOutput("sf_flush_valid", ex_valid, 0);
        checkOutput("sf_flush_op", alu_op, 3'b000);
        flush = 0;
        clearBypass();

        // Hazard is masked while flush is high
        applyStimulus(1, 5'd2, 32'h100, 5'd0, 32'd0, 5'd6, 32'd4, 1, 3'b100, 1, 1, 0);
        step();
        applyStimulus(1, 5'd6, 32'd0, 5'd0, 32'd0, 5'd7, 32'd1, 1, 3'b100, 1, 0, 0);
        flush = 1;
        #1;
        checkOutput("flush_masks_lus", load_use_stall, 0);
        flush = 0;
        #1;
        checkOutput("lus_rs_match", load_use_stall, 1);
        step();

        // Async reset mid-stall while EX holds a real instruction
        applyStimulus(1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'h1234, 1, 3'b100, 1, 0, 0);
        step();
        checkOutput("ar_pre_valid", ex_valid, 1);
        stall = 1;
        #1;
        rst_n = 0;
        #1;
        checkOutput("ar_valid", ex_valid, 0);
        checkOutput("ar_alu_b", alu_b, 0);
        checkOutput("ar_rd", ex_rd_addr, 0);
        checkOutput("ar_rw", ex_reg_write, 0);
        checkOutput("ar_lus", load_use_stall, 0);
        step();
        rst_n = 1; stall = 0;
        step();
        checkOutput("ar_post_valid", ex_valid, 1);
        checkOutput("ar_post_alu_b", alu_b, 32'h1234);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
